// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving the 8-bit ALU and returning its result over valid/ready.
// Optional feature macro: MUL_EN enables the 8x8 shift-add multiply on op 4'hB.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [3:0] alu_alus,
    output logic [7:0] alu_x,
    output logic [7:0] alu_bus,
    input  logic [7:0] alu_dout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic       busy
);

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ZERO = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_PASS = OPW'(4'hA);
`ifdef MUL_EN
    localparam logic [OPW-1:0] OP_MUL  = OPW'(4'hB);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
`ifdef MUL_EN
        S_MADD,
        S_MSHL,
`endif
        S_RESP
    } state_t;

    state_t state_q;

`ifdef MUL_EN
    logic [DW-1:0] p_q;
    logic [DW-1:0] m_q;
    logic [DW-1:0] q_q;
    logic [2:0]    i_q;
`endif

    // Handshake status decoded from state only; rst masks ready while held.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            alu_alus  <= OP_ZERO;
            alu_x     <= '0;
            alu_bus   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef MUL_EN
            p_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            i_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op <= OP_PASS) begin
                            state_q  <= S_EXEC;
                            alu_alus <= cmd_op;
                            alu_x    <= cmd_a;
                            alu_bus  <= cmd_b;
`ifdef MUL_EN
                        end else if (cmd_op == OP_MUL) begin
                            state_q  <= S_MADD;
                            p_q      <= '0;
                            m_q      <= cmd_a;
                            q_q      <= cmd_b;
                            i_q      <= '0;
                            alu_x    <= '0;
                            alu_alus <= cmd_b[0] ? OP_ADD : OP_PASS;
                            alu_bus  <= cmd_b[0] ? cmd_a : DW'(0);
`endif
                        end else begin
                            state_q   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state_q   <= S_RESP;
                    alu_alus  <= OP_ZERO;
                    alu_x     <= '0;
                    alu_bus   <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_dout;
                    rsp_zero  <= (alu_dout == '0);
                    rsp_err   <= 1'b0;
                end
`ifdef MUL_EN
                S_MADD: begin
                    state_q  <= S_MSHL;
                    p_q      <= alu_dout;
                    alu_alus <= OP_SHL;
                    alu_x    <= m_q;
                    alu_bus  <= '0;
                end
                S_MSHL: begin
                    m_q <= alu_dout;
                    q_q <= q_q >> 1;
                    i_q <= i_q + 3'd1;
                    if (i_q != 3'd7) begin
                        // Next partial-product step looks at the multiplier bit about to reach Q[0].
                        state_q  <= S_MADD;
                        alu_x    <= p_q;
                        alu_alus <= q_q[1] ? OP_ADD : OP_PASS;
                        alu_bus  <= q_q[1] ? alu_dout : p_q;
                    end else begin
                        state_q   <= S_RESP;
                        alu_alus  <= OP_ZERO;
                        alu_x     <= '0;
                        alu_bus   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= p_q;
                        rsp_zero  <= (p_q == '0);
                        rsp_err   <= 1'b0;
                    end
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q   <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural ALU and a response scoreboard.
// Follows the MUL_EN setting of the build for op 4'hB.
module tb_alu_seq;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'h0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [3:0] alu_alus;
    logic [7:0] alu_x;
    logic [7:0] alu_bus;
    logic [7:0] alu_dout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_err;
    logic       busy;

    rsp_t       exp_q[$];
    logic [3:0] alus_log[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_alus(alu_alus), .alu_x(alu_x), .alu_bus(alu_bus), .alu_dout(alu_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU
    always_comb begin
        case (alu_alus)
            4'h1:    alu_dout = alu_x + alu_bus;
            4'h2:    alu_dout = alu_x - alu_bus;
            4'h3:    alu_dout = alu_x + 8'd1;
            4'h4:    alu_dout = alu_x - 8'd1;
            4'h5:    alu_dout = alu_x & alu_bus;
            4'h6:    alu_dout = alu_x | alu_bus;
            4'h7:    alu_dout = ~alu_x;
            4'h8:    alu_dout = alu_x ^ alu_bus;
            4'h9:    alu_dout = {alu_x[6:0], 1'b0};
            4'hA:    alu_dout = alu_bus;
            default: alu_dout = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        r.err  = 1'b0;
        r.data = 8'h00;
        case (op)
            4'h0: r.data = 8'h00;
            4'h1: r.data = a + b;
            4'h2: r.data = a - b;
            4'h3: r.data = a + 8'd1;
            4'h4: r.data = a - 8'd1;
            4'h5: r.data = a & b;
            4'h6: r.data = a | b;
            4'h7: r.data = ~a;
            4'h8: r.data = a ^ b;
            4'h9: r.data = 8'(a << 1);
            4'hA: r.data = b;
`ifdef MUL_EN
            4'hB: r.data = 8'(16'(a) * 16'(b));
`endif
            default: r.err = 1'b1;
        endcase
        r.zero = (r.data == 8'h00);
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef MUL_EN
        if (op == 4'hB) return 16;
`endif
        if (op <= 4'hA) return 1;
        return 0;
    endfunction

    // Scoreboard: pop on every response handshake
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_zero", rsp_zero, e.zero);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    // ALU function sequence while working
    always @(negedge clk) begin
        if (!rst && busy && !rsp_valid) alus_log.push_back(alu_alus);
    end

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input logic early);
        int         lat;
        logic [7:0] held;
        exp_q.push_back(model(op, a, b));
        alus_log.delete();
        rsp_ready = early;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat(op));
        check("busy_cycles", alus_log.size(), exp_lat(op));
        if (exp_lat(op) == 1 && alus_log.size() == 1)
            check("alus_exec", alus_log[0], op);
        if (exp_lat(op) == 16 && alus_log.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                check("alus_madd", alus_log[2*k], b[k] ? 4'h1 : 4'hA);
                check("alus_mshl", alus_log[2*k+1], 4'h9);
            end
        end
        check("alu_resp_zero", {alu_alus, alu_x, alu_bus}, 20'h0);
        held = rsp_data;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                cmd_valid = 1'b1;
                cmd_op    = 4'h1;
                @(negedge clk);
                check("bp_data_stable", rsp_data, held);
                check("bp_cmd_ready", cmd_ready, 1'b0);
                check("bp_valid", rsp_valid, 1'b1);
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_drop", rsp_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
        check("idle_after", busy, 1'b0);
        check("sb_drained", exp_q.size(), 0);
        rsp_ready = 1'b0;
    endtask

    task automatic reset_mid(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input int cyc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (cyc - 1) begin
            @(posedge clk); #1;
        end
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_outputs",
              {cmd_ready, alu_alus, alu_x, alu_bus, rsp_valid, rsp_data, rsp_zero, rsp_err, busy},
              32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_outputs",
              {alu_alus, alu_x, alu_bus, rsp_valid, rsp_data, rsp_zero, rsp_err, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_release", cmd_ready, 1'b1);

        run_op(4'h1, 8'h3C, 8'h14, 0, 1'b0);
        run_op(4'h2, 8'h05, 8'h07, 0, 1'b0);
        run_op(4'h3, 8'hFF, 8'h00, 0, 1'b0);
        run_op(4'h4, 8'h00, 8'h00, 0, 1'b0);
        run_op(4'h5, 8'hF0, 8'h3C, 0, 1'b0);
        run_op(4'h6, 8'hA0, 8'h05, 0, 1'b0);
        run_op(4'h7, 8'hA5, 8'h00, 0, 1'b0);
        run_op(4'h8, 8'hFF, 8'h0F, 0, 1'b0);
        run_op(4'h9, 8'h81, 8'h00, 0, 1'b0);
        run_op(4'hA, 8'h12, 8'h77, 0, 1'b0);
        run_op(4'h0, 8'h55, 8'hAA, 0, 1'b0);
        run_op(4'h1, 8'hFF, 8'h01, 0, 1'b0);
        run_op(4'hC, 8'h12, 8'h34, 0, 1'b0);
        run_op(4'hF, 8'hFF, 8'hFF, 0, 1'b0);
        run_op(4'hB, 8'd13, 8'd11, 0, 1'b0);
        run_op(4'hB, 8'd16, 8'd16, 0, 1'b0);
        run_op(4'hB, 8'hFF, 8'hFF, 0, 1'b0);
        run_op(4'h2, 8'h40, 8'h01, 5, 1'b0);
        run_op(4'hB, 8'h07, 8'h09, 3, 1'b0);
        run_op(4'h6, 8'h0C, 8'h30, 0, 1'b1);
        run_op(4'hD, 8'h01, 8'h02, 0, 1'b1);

`ifdef MUL_EN
        reset_mid(4'hB, 8'd13, 8'd11, 7);
`else
        reset_mid(4'h1, 8'h3C, 8'h14, 1);
`endif
        run_op(4'h1, 8'h01, 8'h01, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_op(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)),
                   8'($urandom_range(255, 0)), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle command sequencer for the 8-bit ALU. It accepts one operation at a time over a valid/ready command port and drives the ALU's function select, X operand and bus operand. It captures the ALU result and returns it on a valid/ready response port. Under configuration it also synthesises an 8×8 multiply as a shift-add loop on the ALU's add and shift-left functions. It sits between the control unit and the ALU and is the only block that drives the ALU's inputs.

## Interface
Parameters:
- none (widths fixed: 8-bit data, 4-bit function code)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  function code
- cmd_a  in  8  operand A (ALU X side)
- cmd_b  in  8  operand B (ALU bus side)
- alu_alus  out  4  to ALU function select
- alu_x  out  8  to ALU X input
- alu_bus  out  8  to ALU bus input
- alu_dout  in  8  ALU result, combinational from the three outputs above
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  result
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  illegal op; rsp_data = 0
- busy  out  1  state != IDLE

## Operation
- ALU codes passed through unchanged:
  - 0 zero, 1 add, 2 sub, 3 inc, 4 dec, 5 and, 6 or, 7 not, 8 xor, 9 shl, A pass-bus.
  - 4'hB is MUL (see Configuration).
  - 4'hC–4'hF are always illegal.
- States: IDLE, EXEC, MADD, MSHL, RESP.
- IDLE:
  - cmd_ready = 1 (forced 0 while rst high).
  - On cmd_valid && cmd_ready, latch op/A/B.
  - Next state: EXEC for codes 0–A; MADD for MUL; RESP with rsp_err = 1 for illegal codes.
- EXEC (one cycle):
  - alu_alus = op, alu_x = A, alu_bus = B.
  - alu_dout is registered into the result; next state RESP.
- MUL registers: P = 0, M = A, Q = B, iteration counter i = 0.
- MADD (one cycle):
  - If Q[0]: alu_alus = 1, alu_x = P, alu_bus = M.
  - Else: alu_alus = 4'hA, alu_x = P, alu_bus = P.
  - P <= alu_dout; next state MSHL.
- MSHL (one cycle):
  - alu_alus = 9, alu_x = M, alu_bus = 0.
  - M <= alu_dout; Q <= Q >> 1; i <= i + 1.
  - Next state: MADD if i != 7; otherwise RESP with result = P.
- MUL result is the low 8 bits of A×B; the overflow is discarded silently and there is no carry flag.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_zero and rsp_err are held stable.
  - On rsp_ready, return to IDLE.
- ALU outputs are all zero in IDLE and RESP, so the ALU always sees code 0.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE; cmd_ready 0 during rst, 1 in the first cycle after release.
  - rsp_valid, rsp_data, rsp_zero, rsp_err, busy, alu_alus, alu_x, alu_bus are all 0.
  - P, M, Q, i are 0.
- All outputs are registered or decoded from state plus registers; there is no combinational path from cmd_* or rsp_ready to any output.
- Simple op: accept at edge E0; EXEC during the following cycle; rsp_valid high after E1.
- Illegal op: rsp_valid high after E0.
- MUL: 16 ALU cycles (8 × MADD/MSHL, fixed, no early exit); rsp_valid high after E16.
- Response handshake:
  - Transfer on the edge where rsp_valid && rsp_ready.
  - rsp_valid drops after that edge; cmd_ready rises in the same cycle (IDLE).
  - Back-to-back throughput: one simple op per 3 cycles.
- rsp_ready held high before rsp_valid: the transfer occurs on the first RESP edge.
- rst asserted mid-operation: immediate return to IDLE with all reset values; the partial result is lost and no response is issued.
- Wrap-around follows 8-bit ALU arithmetic: 0xFF+1 = 0x00 with rsp_zero = 1.

## Configuration
- MUL_EN defined:
  - 4'hB performs the shift-add multiply above.
- MUL_EN undefined:
  - MADD, MSHL, P/M/Q/i are not compiled.
  - 4'hB is treated as illegal: response after one edge with rsp_err = 1 and rsp_data = 0.

## Test plan
- ADD: op 1, A 0x3C, B 0x14 → alu_alus = 1 for exactly one cycle; rsp_data 0x50, rsp_zero 0, rsp_err 0, rsp_valid after E1.
- SUB wrap / INC zero:
  - op 2, 0x05 − 0x07 → 0xFE.
  - op 3, A 0xFF → 0x00, rsp_zero 1.
- MUL (MUL_EN):
  - 13 × 11 → 0x8F after exactly 16 busy cycles.
  - 16 × 16 → 0x00, rsp_zero 1.
  - Check the alu_alus sequence alternates {1 or A}, 9.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid → rsp_data stable, cmd_ready 0, a second cmd_valid is not accepted until after the transfer.
- Reset mid-MUL: assert rst at MUL cycle 7 → all outputs 0 immediately; the next ADD 0x01+0x01 returns 0x02 with normal timing.
- Illegal op: op 0xC → rsp_err 1, rsp_data 0, alu_alus never leaves 0. Without MUL_EN, op 0xB gives the same response.
